// File: rtl/serial_dram_bridge.sv
// serial_dram_bridge: parses framed UART read/write commands and issues
// single-beat MIG app-interface transactions, answering over the UART.
module serial_dram_bridge #(
    parameter int ADDR_WIDTH     = 28,
    parameter int DATA_WIDTH     = 128,
    parameter int TIMEOUT_CYCLES = 10_000_000
) (
    input  logic                    ui_clk,
    input  logic                    sys_rst,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic [7:0]              tx_data,
    output logic                    tx_valid,
    input  logic                    tx_ready,
    output logic [ADDR_WIDTH-1:0]   app_addr,
    output logic [2:0]              app_cmd,
    output logic                    app_en,
    input  logic                    app_rdy,
    output logic [DATA_WIDTH-1:0]   app_wdf_data,
    output logic [DATA_WIDTH/8-1:0] app_wdf_mask,
    output logic                    app_wdf_wren,
    output logic                    app_wdf_end,
    input  logic                    app_wdf_rdy,
    input  logic [DATA_WIDTH-1:0]   app_rd_data,
    input  logic                    app_rd_data_valid,
    output logic                    busy,
    output logic                    err_overrun
);

    localparam int AB = (ADDR_WIDTH + 7) / 8;
    localparam int DB = DATA_WIDTH / 8;
    localparam int NB = (AB > DB) ? AB : DB;
    localparam int CW = (NB > 1) ? $clog2(NB) : 1;
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [CW-1:0] AB_LAST  = CW'(AB - 1);
    localparam logic [CW-1:0] DB_LAST  = CW'(DB - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] CH_W    = 8'h57;
    localparam logic [7:0] CH_R    = 8'h52;
    localparam logic [7:0] CH_ACK  = 8'h4B;
    localparam logic [7:0] CH_BAD  = 8'h3F;
    localparam logic [7:0] CH_TMO  = 8'h21;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WISSUE, S_TXACK,
        S_RISSUE, S_RWAIT, S_TXDATA, S_TXERR
    } state_t;

    state_t                  state_q, state_d;
    logic                    rd_q, rd_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [TW-1:0]           tmo_q, tmo_d;
    logic                    en_pend_q, en_pend_d;
    logic                    wr_pend_q, wr_pend_d;
    logic [7:0]              err_byte_q, err_byte_d;
    logic                    ovr_q, ovr_d;

    // State and datapath registers, cleared asynchronously.
    always_ff @(posedge ui_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q    <= S_IDLE;
            rd_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            en_pend_q  <= 1'b0;
            wr_pend_q  <= 1'b0;
            err_byte_q <= '0;
            ovr_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            rd_q       <= rd_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            en_pend_q  <= en_pend_d;
            wr_pend_q  <= wr_pend_d;
            err_byte_q <= err_byte_d;
            ovr_q      <= ovr_d;
        end
    end

    // Next-state logic: frame parsing, app handshakes, tx sequencing, timeout.
    always_comb begin
        state_d    = state_q;
        rd_d       = rd_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cnt_d      = cnt_q;
        tmo_d      = '0;
        en_pend_d  = en_pend_q;
        wr_pend_d  = wr_pend_q;
        err_byte_d = err_byte_q;
        ovr_d      = ovr_q;

        if ((state_q == S_ADDR || state_q == S_WDATA) && !rx_valid)
            tmo_d = tmo_q + TW'(1);

        if (rx_valid && state_q != S_IDLE && state_q != S_ADDR && state_q != S_WDATA)
            ovr_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (rx_valid) begin
                    if (rx_data == CH_W) begin
                        rd_d    = 1'b0;
                        state_d = S_ADDR;
                    end else if (rx_data == CH_R) begin
                        rd_d    = 1'b1;
                        state_d = S_ADDR;
                    end else begin
                        err_byte_d = CH_BAD;
                        state_d    = S_TXERR;
                    end
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    addr_d = (addr_q << 8) | ADDR_WIDTH'(rx_data);
                    if (cnt_q == AB_LAST) begin
                        cnt_d   = '0;
                        state_d = rd_q ? S_RISSUE : S_WDATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_byte_d = CH_TMO;
                    state_d    = S_TXERR;
                end
            end
            S_WDATA: begin
                if (rx_valid) begin
                    wdata_d[cnt_q*8 +: 8] = rx_data;
                    if (cnt_q == DB_LAST) begin
                        cnt_d     = '0;
                        en_pend_d = 1'b1;
                        wr_pend_d = 1'b1;
                        state_d   = S_WISSUE;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_byte_d = CH_TMO;
                    state_d    = S_TXERR;
                end
            end
            S_WISSUE: begin
                // Command and write data retire independently; leave once both are gone.
                en_pend_d = en_pend_q & ~app_rdy;
                wr_pend_d = wr_pend_q & ~app_wdf_rdy;
                if (!en_pend_d && !wr_pend_d)
                    state_d = S_TXACK;
            end
            S_TXACK: if (tx_ready) state_d = S_IDLE;
            S_RISSUE: if (app_rdy) state_d = S_RWAIT;
            S_RWAIT: begin
                if (app_rd_data_valid) begin
                    rdata_d = app_rd_data;
                    cnt_d   = '0;
                    state_d = S_TXDATA;
                end
            end
            S_TXDATA: begin
                if (tx_ready) begin
                    if (cnt_q == DB_LAST) state_d = S_IDLE;
                    else                  cnt_d   = cnt_q + CW'(1);
                end
            end
            S_TXERR: if (tx_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from registered state.
    always_comb begin
        tx_data = '0;
        case (state_q)
            S_TXACK:  tx_data = CH_ACK;
            S_TXERR:  tx_data = err_byte_q;
            S_TXDATA: tx_data = rdata_q[cnt_q*8 +: 8];
            default:  tx_data = '0;
        endcase
    end

    assign tx_valid     = (state_q == S_TXACK) || (state_q == S_TXERR) || (state_q == S_TXDATA);
    assign app_addr     = addr_q;
    assign app_cmd      = {2'b00, rd_q};
    assign app_en       = (state_q == S_RISSUE) || ((state_q == S_WISSUE) && en_pend_q);
    assign app_wdf_data = wdata_q;
    assign app_wdf_mask = '0;
    assign app_wdf_wren = (state_q == S_WISSUE) && wr_pend_q;
    assign app_wdf_end  = app_wdf_wren;
    assign busy         = (state_q != S_IDLE);
    assign err_overrun  = ovr_q;

endmodule

// File: doc/serial_dram_bridge.md
# serial_dram_bridge

Byte-protocol command bridge between the UART byte streams and the MIG user (app) interface, clocked in the `ui_clk` domain inside `serial_dram_top`. It parses framed read/write commands from the UART receiver, issues single-beat app-interface transactions and returns acknowledgements or read data through the UART transmitter. Address and data widths are parameters, and the block adds an inter-byte timeout and error responses.

## Interface
- `ADDR_WIDTH`, default 28: app address width. Address bytes per frame `AB = ceil(ADDR_WIDTH/8)`.
- `DATA_WIDTH`, default 128: app data width, multiple of 8. Data bytes per frame `DB = DATA_WIDTH/8`.
- `TIMEOUT_CYCLES`, default 10_000_000: maximum idle cycles between bytes inside a frame.
- `ui_clk` in 1: sole clock.
- `sys_rst` in 1: asynchronous, active-low reset.
- `rx_data` in 8: received byte.
- `rx_valid` in 1: one-cycle strobe, `rx_data` valid.
- `tx_data` out 8: byte to transmit.
- `tx_valid` out 1: byte offered to the transmitter.
- `tx_ready` in 1: transmitter accepts the byte on `tx_valid & tx_ready`.
- `app_addr` out ADDR_WIDTH: command address.
- `app_cmd` out 3: 3'b000 = write, 3'b001 = read.
- `app_en` out 1, `app_rdy` in 1: command handshake.
- `app_wdf_data` out DATA_WIDTH, `app_wdf_mask` out DATA_WIDTH/8 (always 0), `app_wdf_wren` out 1, `app_wdf_end` out 1 (equal to `app_wdf_wren`), `app_wdf_rdy` in 1: write-data handshake.
- `app_rd_data` in DATA_WIDTH, `app_rd_data_valid` in 1: read return.
- `busy` out 1: high in any state other than IDLE.
- `err_overrun` out 1: sticky; set when an `rx_valid` byte is dropped.

## Operation
- Frame: command byte, then AB address bytes (big-endian, MSB first), then for a write DB data bytes (little-endian, byte 0 = bits [7:0]). Address bits above ADDR_WIDTH are discarded.
- Commands: 0x57 'W' = write; 0x52 'R' = read. Any other byte in IDLE sends 0x3F '?' and returns to IDLE.
- States: IDLE → ADDR → (W: WDATA → WISSUE → TXACK) or (R: RISSUE → RWAIT → TXDATA); TXERR; all of these end in IDLE.
- WISSUE: `app_en` and `app_wdf_wren` are asserted together. Each deasserts independently on its own handshake (`app_rdy` for `app_en`, `app_wdf_rdy` for `app_wdf_wren`). Leave WISSUE when both have been accepted, in either order or in the same cycle. TXACK then sends 0x4B 'K'.
- RISSUE: hold `app_en` with `app_cmd` = 001 until `app_rdy`. RWAIT: capture `app_rd_data` on `app_rd_data_valid`. TXDATA: send DB bytes, LSB byte first.
- `app_addr`, `app_cmd` and `app_wdf_data` are stable while their enable is high.
- Timeout: a counter runs in ADDR and WDATA only and clears on every accepted byte. When it reaches TIMEOUT_CYCLES, abandon the frame, go to TXERR, send 0x21 '!' and return to IDLE. No app command is issued for an abandoned frame.
- In WISSUE, RISSUE, RWAIT, TXDATA, TXACK and TXERR, `rx_valid` bytes are dropped and `err_overrun` is set. `err_overrun` clears only on reset.
- `app_rd_data_valid` outside RWAIT is ignored.

## Timing
- Reset: every output is 0. The state machine and counters reset to IDLE / 0 asynchronously and immediately. A reset in mid-transaction drops any pending handshake with no completion.
- A byte is consumed in the cycle its `rx_valid` is high. The state advances on the next edge.
- `app_en` rises on the cycle after the last address byte (read) or the last data byte (write).
- `tx_valid` rises on the cycle after: the read-data capture, the final accepted write handshake, the error/timeout event, or the bad command byte.
- `tx_valid` stays high, and `tx_data` stays stable, until `tx_ready`. The next byte is presented on the following cycle.
- Return to IDLE happens on the cycle after the last tx handshake. A new frame is accepted from that cycle.
- Timeout fires exactly TIMEOUT_CYCLES cycles after the last accepted byte.

## Test plan
Bench parameters: ADDR_WIDTH = 16, DATA_WIDTH = 32 (so AB = 2, DB = 4); `tx_ready` tied high unless stated.
- Write: send 57 12 34 EF BE AD DE with `app_rdy` and `app_wdf_rdy` high → exactly one cycle with `app_en`, `app_cmd` = 0, `app_addr` = 0x1234, `app_wdf_data` = 0xDEADBEEF, `app_wdf_end` = 1. Then 'K' (0x4B) is transmitted.
- Read: send 52 12 34; the model returns 0xDEADBEEF 5 cycles after accept → `app_cmd` = 1, `app_addr` = 0x1234. Transmitted bytes are EF, BE, AD, DE.
- Independent write handshakes: `app_wdf_rdy` high immediately, `app_rdy` low for 10 cycles → `app_wdf_wren` is high for 1 cycle and `app_en` for 11 cycles. 'K' is sent only after both are accepted.
- Backpressure: `tx_ready` toggles every 3 cycles during a read → each byte is held stable until accepted, with no loss or duplication.
- Timeout: with TIMEOUT_CYCLES = 100, send 57 12 then nothing → '!' (0x21) is sent 101 cycles later, no `app_en`, and `busy` falls. A following valid read completes normally.
- Errors and reset: byte 0x41 in IDLE → '?' (0x3F). A byte arriving during RWAIT → `err_overrun` = 1. Asserting `sys_rst` low during RISSUE → all outputs are 0 immediately.
